// File: rtl/aes_pkg.sv
// Shared types, S-box tables and byte-level helpers for the AES-128 decryption slice.
// Both tables are stored row-major with entry 0x00 in the most significant byte.
package aes_pkg;
    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEYEXP, ST_ARK_INIT, ST_ISR, ST_ISB, ST_ARK, ST_IMC, ST_DONE
    } aes_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD, SEL_INIT, SEL_ISR, SEL_ISB, SEL_ARK, SEL_IMC
    } blk_sel_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] v;
        case (r)
            1:       v = 8'h01;
            2:       v = 8'h02;
            3:       v = 8'h04;
            4:       v = 8'h08;
            5:       v = 8'h10;
            6:       v = 8'h20;
            7:       v = 8'h40;
            8:       v = 8'h80;
            9:       v = 8'h1b;
            10:      v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte n of the block sits at bits 127-8n; row r of column c is byte 4c+r.
    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_dec_fsm.sv
// Sequencer for the iterative decryptor: state, round and column counters, datapath selects.
module aes_dec_fsm
    import aes_pkg::*;
#(
    parameter int KEYEXP_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] round,
    output logic [1:0] word,
    output blk_sel_t   blk_sel,
    output logic       capture,
    output logic       done_set,
    output logic       done_clr
);
    localparam logic [4:0] CYC_LAST   = 5'(KEYEXP_CYCLES - 1);
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);

    aes_state_t state;
    logic [4:0] cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            round <= '0;
            word  <= '0;
            cyc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cyc <= '0;
                    if (start) state <= ST_KEYEXP;
                end
                ST_KEYEXP: begin
                    if (cyc == CYC_LAST) state <= ST_ARK_INIT;
                    else                 cyc   <= cyc + 5'd1;
                end
                ST_ARK_INIT: begin
                    round <= ROUND_LAST;
                    state <= ST_ISR;
                end
                ST_ISR: state <= ST_ISB;
                ST_ISB: state <= ST_ARK;
                ST_ARK: state <= (round == 4'd0) ? ST_DONE : ST_IMC;
                ST_IMC: begin
                    word <= word + 2'd1;
                    if (word == 2'd3) begin
                        round <= round - 4'd1;
                        state <= ST_ISR;
                    end
                end
                ST_DONE: begin
                    if (!start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        blk_sel = SEL_HOLD;
        case (state)
            ST_ARK_INIT: blk_sel = SEL_INIT;
            ST_ISR:      blk_sel = SEL_ISR;
            ST_ISB:      blk_sel = SEL_ISB;
            ST_ARK:      blk_sel = SEL_ARK;
            ST_IMC:      blk_sel = SEL_IMC;
            default:     blk_sel = SEL_HOLD;
        endcase
    end

    // The last AddRoundKey publishes the plaintext on the same edge that enters DONE.
    assign capture  = (state == ST_IDLE) && start;
    assign done_set = (state == ST_ARK) && (round == 4'd0);
    assign done_clr = capture || ((state == ST_DONE) && !start);
endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns on one 32-bit column; the top byte (bits 31:24) is row 0.
module inv_mix_columns (
    input  logic [31:0] column,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 9, 11, 13 or 14 in GF(2^8) built from doublings.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = column;

    assign mixed[31:24] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign mixed[23:16] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign mixed[15:8]  = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign mixed[7:0]   = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
endmodule

// File: rtl/inv_sub_bytes.sv
// Single-byte inverse S-box lookup.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);
    assign result = inv_sbox(value);
endmodule

// File: rtl/key_expansion.sv
// Combinational AES-128 key schedule producing all eleven round keys from one cipher key.
module key_expansion
    import aes_pkg::*;
(
    input  logic [127:0]                key,
    output aes_block_t [NUM_ROUNDS:0]   round_keys
);
    aes_word_t w [4*(NUM_ROUNDS+1)];

    always_comb begin
        aes_word_t t;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            w[i] = key[127 - 32*i -: 32];
        end
        for (int i = 4; i < 4*(NUM_ROUNDS+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4), 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NUM_ROUNDS; r++) begin
            round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end
endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core behind the Avalon-MM register block.
// Inputs are latched on start; one inverse-round step per cycle, one IMC column per cycle.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int KEYEXP_CYCLES = 12
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_ENC,
    output logic         AES_DONE,
    output logic [127:0] AES_MSG_DEC
);
    logic [127:0] key_q;
    logic [127:0] enc_q;
    logic [127:0] blk_q;
    logic [127:0] blk_next;
    logic [127:0] isb_out;
    logic [127:0] ark_out;
    logic [127:0] imc_next;
    logic [31:0]  imc_in;
    logic [31:0]  imc_out;

    aes_block_t [NUM_ROUNDS:0] round_keys;

    logic [3:0] round;
    logic [1:0] word;
    blk_sel_t   blk_sel;
    logic       capture;
    logic       done_set;
    logic       done_clr;

    aes_dec_fsm #(.KEYEXP_CYCLES(KEYEXP_CYCLES)) u_fsm (
        .clk      (CLK),
        .rst      (RESET),
        .start    (AES_START),
        .round    (round),
        .word     (word),
        .blk_sel  (blk_sel),
        .capture  (capture),
        .done_set (done_set),
        .done_clr (done_clr)
    );

    key_expansion u_keyexp (
        .key        (key_q),
        .round_keys (round_keys)
    );

    for (genvar i = 0; i < 16; i++) begin : g_isb
        inv_sub_bytes u_isb (
            .value  (blk_q[8*i +: 8]),
            .result (isb_out[8*i +: 8])
        );
    end

    inv_mix_columns u_imc (
        .column (imc_in),
        .mixed  (imc_out)
    );

    assign ark_out = blk_q ^ round_keys[round];

    // Column 0 is the most significant word of the block.
    always_comb begin
        imc_in   = blk_q[127:96];
        imc_next = blk_q;
        case (word)
            2'd0: begin imc_in = blk_q[127:96]; imc_next[127:96] = imc_out; end
            2'd1: begin imc_in = blk_q[95:64];  imc_next[95:64]  = imc_out; end
            2'd2: begin imc_in = blk_q[63:32];  imc_next[63:32]  = imc_out; end
            default: begin imc_in = blk_q[31:0]; imc_next[31:0] = imc_out; end
        endcase
    end

    always_comb begin
        blk_next = blk_q;
        case (blk_sel)
            SEL_INIT: blk_next = enc_q ^ round_keys[NUM_ROUNDS];
            SEL_ISR:  blk_next = inv_shift_rows(blk_q);
            SEL_ISB:  blk_next = isb_out;
            SEL_ARK:  blk_next = ark_out;
            SEL_IMC:  blk_next = imc_next;
            default:  blk_next = blk_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_q       <= '0;
            enc_q       <= '0;
            blk_q       <= '0;
            AES_DONE    <= 1'b0;
            AES_MSG_DEC <= '0;
        end else begin
            blk_q <= blk_next;
            if (capture) begin
                key_q <= AES_KEY;
                enc_q <= AES_MSG_ENC;
            end
            if (done_set) begin
                AES_DONE    <= 1'b1;
                AES_MSG_DEC <= ark_out;
            end else if (done_clr) begin
                AES_DONE    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core: known-answer vectors, handshake timing and reset behaviour.
module tb_aes_decrypt_core;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] enc;
    logic         done;
    logic [127:0] dec;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'hdaec3055df058e1c39e814ea76f6747e;
    localparam logic [127:0] PT2  = 128'hece298dcece298dcece298dcece298dc;

    aes_decrypt_core #(.KEYEXP_CYCLES(12)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .AES_START   (start),
        .AES_KEY     (key),
        .AES_MSG_ENC (enc),
        .AES_DONE    (done),
        .AES_MSG_DEC (dec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller has just raised start at a negedge; the next posedge is edge 0.
    task automatic wait_done(input int change_at, output int lat);
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == change_at) begin
                key = '0;
                enc = '1;
            end
            if (done && lat < 0) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int rises;
        int highs;
        int lows;
        int first;
        logic prev;

        rst = 1'b1; start = 1'b0; key = '0; enc = '0;
        #2;
        check("reset_done", 128'(done), 128'd0);
        check("reset_dec", dec, '0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 C.1 known answer
        @(negedge clk);
        key = KEY1; enc = CT1; start = 1'b1;
        wait_done(-1, lat);
        check("fips_latency", 128'(lat), 128'd79);
        check("fips_dec", dec, PT1);
        repeat (5) @(posedge clk);
        #1;
        check("fips_done_held", 128'(done), 128'd1);
        check("fips_dec_held", dec, PT1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("fips_done_clr", 128'(done), 128'd0);
        check("fips_dec_kept", dec, PT1);

        // Course vector with the same key
        @(negedge clk);
        enc = CT2; start = 1'b1;
        wait_done(-1, lat);
        check("course_latency", 128'(lat), 128'd79);
        check("course_dec", dec, PT2);
        repeat (10) @(posedge clk);
        #1;
        check("course_done_held", 128'(done), 128'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("course_done_clr", 128'(done), 128'd0);
        check("course_dec_kept", dec, PT2);

        // Inputs change after edge 20: the latched copies must be used
        @(negedge clk);
        key = KEY1; enc = CT1; start = 1'b1;
        wait_done(20, lat);
        check("midchange_latency", 128'(lat), 128'd79);
        check("midchange_dec", dec, PT1);
        @(negedge clk);
        start = 1'b0; key = KEY1; enc = CT2;
        @(posedge clk);
        #1;
        check("midchange_done_clr", 128'(done), 128'd0);

        // Asynchronous reset pulse between edges during a run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_done", 128'(done), 128'd0);
        check("async_rst_dec", dec, '0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(-1, lat);
        check("post_rst_latency", 128'(lat), 128'd79);
        check("post_rst_dec", dec, PT2);

        // Start kept high: done must stay high with no retrigger
        lows = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (!done) lows++;
        end
        check("held_no_retrigger", 128'(lows), 128'd0);
        check("held_dec", dec, PT2);

        // Back-to-back: one low cycle, then a 200-cycle held start
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        enc = CT1; start = 1'b1;
        @(posedge clk);
        #1;
        prev = done;
        rises = 0; first = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done && !prev) rises++;
            if (done && first < 0) first = n;
            prev = done;
        end
        check("b2b_prev_low", 128'(rises), 128'd1);
        check("b2b_latency", 128'(first), 128'd79);
        check("b2b_dec", dec, PT1);

        // Single-cycle start pulse: done lasts exactly one cycle
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        enc = CT2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        highs = 0; first = -1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (done) highs++;
            if (done && first < 0) first = n;
        end
        check("pulse_done_width", 128'(highs), 128'd1);
        check("pulse_latency", 128'(first), 128'd79);
        check("pulse_dec", dec, PT2);
        check("pulse_done_low", 128'(done), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
